// File: rtl/numbers_overlay.sv
// On-screen numeric overlay: NUM_CH 16-bit values rendered as scaled 8x8 glyph rows.
// Values are snapshotted at frame start and converted into a bank that swaps atomically.
module numbers_overlay #(
    parameter int unsigned NUM_CH    = 3,
    parameter int unsigned X0        = 16,
    parameter int unsigned Y0        = 16,
    parameter int unsigned SCALE_SH  = 1,
    parameter int unsigned ROW_PITCH = 24
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [9:0]           x_px,
    input  logic [9:0]           y_px,
    input  logic [NUM_CH*16-1:0] values,
    input  logic                 dec_mode,
    output logic                 pixel_on,
    output logic                 busy
);

    localparam int unsigned CW      = 8 << SCALE_SH;
    localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned BCD_W   = 20;
    localparam int unsigned CODE_W  = 5;
    localparam int unsigned COORD_W = 11;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, COMMIT} state_t;

    state_t state, state_nxt;

    logic [15:0]        shadow_ch [NUM_CH];
    logic               shadow_dec;
    logic [CH_W-1:0]    ch_cnt;
    logic [CNT_W-1:0]   bit_cnt;
    logic [15:0]        bin;
    logic [BCD_W-1:0]   bcd;
    logic [3:0]         work_dig [NUM_CH][5];
    logic [3:0]         disp_dig [NUM_CH][5];
    logic               disp_dec;

    logic               trigger;
    logic               last_ch;
    logic               hex_ld, dec_ld, sh_en, sh_last, cm_en, busy_nxt;
    logic [BCD_W-1:0]   bcd_adj;
    logic [BCD_W-1:0]   bcd_nxt;

    // 8x8 font: codes 0-9, A-F, 16 = blank; row 0 in the top byte, bit 7 leftmost
    function automatic logic [63:0] glyph_rom(input logic [CODE_W-1:0] code);
        case (code)
            5'd0:    glyph_rom = 64'h3C666E7666663C00;
            5'd1:    glyph_rom = 64'h1838181818187E00;
            5'd2:    glyph_rom = 64'h3C66060C30607E00;
            5'd3:    glyph_rom = 64'h3C66061C06663C00;
            5'd4:    glyph_rom = 64'h0C1C3C6C7E0C0C00;
            5'd5:    glyph_rom = 64'h7E607C0606663C00;
            5'd6:    glyph_rom = 64'h3C66607C66663C00;
            5'd7:    glyph_rom = 64'h7E660C1818181800;
            5'd8:    glyph_rom = 64'h3C66663C66663C00;
            5'd9:    glyph_rom = 64'h3C66663E06663C00;
            5'd10:   glyph_rom = 64'h183C66667E666600;
            5'd11:   glyph_rom = 64'h7C66667C66667C00;
            5'd12:   glyph_rom = 64'h3C66606060663C00;
            5'd13:   glyph_rom = 64'h786C6666666C7800;
            5'd14:   glyph_rom = 64'h7E60607860607E00;
            5'd15:   glyph_rom = 64'h7E60607860606000;
            default: glyph_rom = 64'h0;
        endcase
    endfunction

    assign trigger = (state == IDLE) && (x_px == 10'd0) && (y_px == 10'd0);
    assign last_ch = (ch_cnt == CH_W'(NUM_CH - 1));

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (trigger) state_nxt = LOAD;
            LOAD:    if (shadow_dec)   state_nxt = SHIFT;
                     else if (last_ch) state_nxt = COMMIT;
            SHIFT:   if (bit_cnt == CNT_W'(15)) state_nxt = last_ch ? COMMIT : LOAD;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Control strobes decoded from the current state
    always_comb begin
        hex_ld   = (state == LOAD) && !shadow_dec;
        dec_ld   = (state == LOAD) && shadow_dec;
        sh_en    = (state == SHIFT);
        sh_last  = (state == SHIFT) && (bit_cnt == CNT_W'(15));
        cm_en    = (state == COMMIT);
        busy_nxt = (state_nxt != IDLE);
    end

    // Double-dabble step: add 3 to every digit >= 5, then shift {bcd, bin} left
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 5; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
        bcd_nxt = {bcd_adj[BCD_W-2:0], bin[15]};
    end

    // Conversion datapath and banks
    always_ff @(posedge clk) begin
        if (reset) begin
            busy       <= 1'b0;
            shadow_dec <= 1'b0;
            ch_cnt     <= '0;
            bit_cnt    <= '0;
            bin        <= '0;
            bcd        <= '0;
            disp_dec   <= 1'b0;
            for (int c = 0; c < int'(NUM_CH); c++) begin
                shadow_ch[c] <= '0;
                for (int d = 0; d < 5; d++) begin
                    work_dig[c][d] <= '0;
                    disp_dig[c][d] <= '0;
                end
            end
        end else begin
            busy <= busy_nxt;
            if (trigger) begin
                for (int c = 0; c < int'(NUM_CH); c++) shadow_ch[c] <= values[16*c +: 16];
                shadow_dec <= dec_mode;
                ch_cnt     <= '0;
            end
            if (dec_ld) begin
                bin     <= shadow_ch[ch_cnt];
                bcd     <= '0;
                bit_cnt <= '0;
            end
            if (hex_ld) begin
                work_dig[ch_cnt][0] <= 4'd0;
                for (int d = 1; d < 5; d++) work_dig[ch_cnt][d] <= shadow_ch[ch_cnt][4*(4-d) +: 4];
                ch_cnt <= ch_cnt + CH_W'(1);
            end
            if (sh_en) begin
                bcd     <= bcd_nxt;
                bin     <= {bin[14:0], 1'b0};
                bit_cnt <= bit_cnt + CNT_W'(1);
            end
            if (sh_last) begin
                for (int d = 0; d < 5; d++) work_dig[ch_cnt][d] <= bcd_nxt[4*(4-d) +: 4];
                ch_cnt <= ch_cnt + CH_W'(1);
            end
            if (cm_en) begin
                disp_dig <= work_dig;
                disp_dec <= shadow_dec;
            end
        end
    end

    logic [COORD_W-1:0] x11, y11, xr, yr;
    logic               in_x, hit;
    logic [CH_W-1:0]    ch_sel;

    assign x11  = {1'b0, x_px};
    assign y11  = {1'b0, y_px};
    assign in_x = (x11 >= COORD_W'(X0)) && (x11 < COORD_W'(X0 + 5*CW));
    assign xr   = x11 - COORD_W'(X0);

    // Channel row hit; unsigned 11-bit compares so nothing above/left of the block wraps in
    always_comb begin
        hit    = 1'b0;
        ch_sel = '0;
        yr     = '0;
        for (int c = 0; c < int'(NUM_CH); c++) begin
            if ((y11 >= COORD_W'(Y0 + c*ROW_PITCH)) && (y11 < COORD_W'(Y0 + c*ROW_PITCH + CW))) begin
                hit    = 1'b1;
                ch_sel = CH_W'(c);
                yr     = y11 - COORD_W'(Y0 + c*ROW_PITCH);
            end
        end
    end

    logic               s1_valid;
    logic [CH_W-1:0]    s1_ch;
    logic [2:0]         s1_dig, s1_row, s1_col;
    logic [3:0]         dig_val;
    logic [CODE_W-1:0]  glyph_code;
    logic [63:0]        glyph_bits;
    logic [7:0]         row_bits;

    // Stage 2 lookup: hex mode blanks the leading digit
    always_comb begin
        dig_val    = disp_dig[s1_ch][s1_dig];
        glyph_code = (!disp_dec && (s1_dig == 3'd0)) ? CODE_W'(16) : {1'b0, dig_val};
        glyph_bits = glyph_rom(glyph_code);
        row_bits   = 8'(glyph_bits >> {~s1_row, 3'b000});
    end

    // Two-stage render pipeline
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_ch    <= '0;
            s1_dig   <= '0;
            s1_row   <= '0;
            s1_col   <= '0;
            pixel_on <= 1'b0;
        end else begin
            s1_valid <= in_x && hit;
            s1_ch    <= ch_sel;
            s1_dig   <= 3'(xr >> (3 + SCALE_SH));
            s1_col   <= 3'(xr >> SCALE_SH);
            s1_row   <= 3'(yr >> SCALE_SH);
            pixel_on <= s1_valid && row_bits[~s1_col];
        end
    end

endmodule

// File: tb/tb_numbers_overlay.sv
// Directed bench for numbers_overlay: busy timing, snapshot behaviour and glyph
// rendering checked against an integer-arithmetic raster model and the font table.
module tb_numbers_overlay;

    localparam int NUM_CH = 3;
    localparam int X0     = 16;
    localparam int Y0     = 16;
    localparam int SH     = 1;
    localparam int RP     = 24;
    localparam int CW     = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  x_px, y_px;
    logic [47:0] values;
    logic        dec_mode;
    logic        pixel_on, busy;

    int checks = 0;
    int errors = 0;
    int exp_c [NUM_CH][5];

    numbers_overlay #(
        .NUM_CH(NUM_CH), .X0(X0), .Y0(Y0), .SCALE_SH(SH), .ROW_PITCH(RP)
    ) dut (
        .clk(clk), .reset(reset), .x_px(x_px), .y_px(y_px),
        .values(values), .dec_mode(dec_mode), .pixel_on(pixel_on), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] font_tb(input int code);
        case (code)
            0:  return 64'h3C666E7666663C00;
            1:  return 64'h1838181818187E00;
            2:  return 64'h3C66060C30607E00;
            3:  return 64'h3C66061C06663C00;
            4:  return 64'h0C1C3C6C7E0C0C00;
            5:  return 64'h7E607C0606663C00;
            6:  return 64'h3C66607C66663C00;
            7:  return 64'h7E660C1818181800;
            8:  return 64'h3C66663C66663C00;
            9:  return 64'h3C66663E06663C00;
            10: return 64'h183C66667E666600;
            11: return 64'h7C66667C66667C00;
            12: return 64'h3C66606060663C00;
            13: return 64'h786C6666666C7800;
            14: return 64'h7E60607860607E00;
            15: return 64'h7E60607860606000;
            default: return 64'h0;
        endcase
    endfunction

    function automatic logic exp_pix(input int x, input int y);
        logic [63:0] g;
        int dx, d, col, row, top;
        if (x < X0 || x >= X0 + 5*CW) return 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            top = Y0 + c*RP;
            if (y >= top && y < top + CW) begin
                dx  = x - X0;
                d   = dx / CW;
                col = (dx % CW) / (1 << SH);
                row = (y - top) / (1 << SH);
                g   = font_tb(exp_c[c][d]);
                return g[63 - 8*row - col];
            end
        end
        return 1'b0;
    endfunction

    task automatic set_exp_zero();
        for (int c = 0; c < NUM_CH; c++) begin
            exp_c[c][0] = 16;
            for (int d = 1; d < 5; d++) exp_c[c][d] = 0;
        end
    endtask

    task automatic set_exp_hex(input int c, input int v);
        exp_c[c][0] = 16;
        exp_c[c][1] = (v >> 12) & 15;
        exp_c[c][2] = (v >> 8) & 15;
        exp_c[c][3] = (v >> 4) & 15;
        exp_c[c][4] = v & 15;
    endtask

    task automatic set_exp_dec(input int c, input int v);
        exp_c[c][0] = v / 10000;
        exp_c[c][1] = (v / 1000) % 10;
        exp_c[c][2] = (v / 100) % 10;
        exp_c[c][3] = (v / 10) % 10;
        exp_c[c][4] = v % 10;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raster the block plus margins; each pixel lands on pixel_on two edges after it is driven
    task automatic scan(input string name);
        logic prev_exp;
        bit   have_prev;
        have_prev = 0;
        prev_exp  = 1'b0;
        for (int y = 14; y < 82; y++) begin
            for (int x = 12; x < 100; x++) begin
                x_px = 10'(x);
                y_px = 10'(y);
                tick();
                if (have_prev) begin
                    checks++;
                    if (pixel_on !== prev_exp) begin
                        errors++;
                        $display("FAIL scan_%s before x=%0d y=%0d: pixel_on=%b expected=%b",
                                 name, x, y, pixel_on, prev_exp);
                    end
                end
                prev_exp  = exp_pix(x, y);
                have_prev = 1;
            end
        end
        tick();
        checks++;
        if (pixel_on !== prev_exp) begin
            errors++;
            $display("FAIL scan_%s last pixel: pixel_on=%b expected=%b", name, pixel_on, prev_exp);
        end
    endtask

    task automatic run_trigger(input int exp_n, input string name,
                               input logic [47:0] post_vals, input logic post_dec);
        int n;
        x_px = 10'd0;
        y_px = 10'd0;
        tick();
        x_px     = 10'd1;
        values   = post_vals;
        dec_mode = post_dec;
        n = 0;
        while (busy === 1'b1 && n < 500) begin
            n++;
            tick();
        end
        checks++;
        if (n !== exp_n) begin
            errors++;
            $display("FAIL busy_len_%s: busy cycles=%0d expected=%0d", name, n, exp_n);
        end
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        values   = '0;
        dec_mode = 1'b0;
        x_px     = 10'(X0 + CW + 4);
        y_px     = 10'(Y0);
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (pixel_on !== 1'b0) begin
                errors++;
                $display("FAIL reset_pixel cycle %0d: pixel_on=%b expected=0", i, pixel_on);
            end
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_busy cycle %0d: busy=%b expected=0", i, busy);
            end
        end
        reset = 1'b0;
        set_exp_zero();
        scan("reset");
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_busy: busy=%b expected=0", busy);
        end
    endtask

    task automatic test_hex();
        values   = {16'h1010, 16'hAAAA, 16'h1111};
        dec_mode = 1'b0;
        run_trigger(NUM_CH + 1, "hex", values, 1'b0);
        set_exp_hex(0, 16'h1111);
        set_exp_hex(1, 16'hAAAA);
        set_exp_hex(2, 16'h1010);
        scan("hex");
    endtask

    task automatic test_decimal();
        values   = {16'd1234, 16'd0, 16'd65535};
        dec_mode = 1'b1;
        run_trigger(17*NUM_CH + 1, "dec", values, 1'b1);
        set_exp_dec(0, 65535);
        set_exp_dec(1, 0);
        set_exp_dec(2, 1234);
        scan("dec");
    endtask

    task automatic test_snapshot();
        values   = {16'h89AB, 16'h4567, 16'h0123};
        dec_mode = 1'b0;
        run_trigger(NUM_CH + 1, "snap", {3{16'hFFFF}}, 1'b1);
        set_exp_hex(0, 16'h0123);
        set_exp_hex(1, 16'h4567);
        set_exp_hex(2, 16'h89AB);
        scan("snap_old");
        dec_mode = 1'b0;
        run_trigger(NUM_CH + 1, "snap_new", values, 1'b0);
        for (int c = 0; c < NUM_CH; c++) set_exp_hex(c, 16'hFFFF);
        scan("snap_new");
    endtask

    task automatic test_reset_mid();
        values   = {16'd9, 16'd10000, 16'd42};
        dec_mode = 1'b1;
        x_px = 10'd0;
        y_px = 10'd0;
        tick();
        x_px = 10'd1;
        for (int i = 1; i < 20; i++) tick();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_busy_cycle20: busy=%b expected=1", busy);
        end
        reset = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_busy: busy=%b expected=0", busy);
        end
        reset = 1'b0;
        set_exp_zero();
        scan("mid_reset");
        run_trigger(17*NUM_CH + 1, "after_reset", values, 1'b1);
        set_exp_dec(0, 42);
        set_exp_dec(1, 10000);
        set_exp_dec(2, 9);
        scan("after_reset");
    endtask

    task automatic test_latency();
        logic e;
        x_px = 10'(X0 - 1);
        y_px = 10'(Y0);
        tick();
        tick();
        checks++;
        if (pixel_on !== 1'b0) begin
            errors++;
            $display("FAIL left_edge: pixel_on=%b expected=0", pixel_on);
        end
        x_px = 10'(X0 + 4);
        e    = exp_pix(X0 + 4, Y0);
        tick();
        checks++;
        if (pixel_on !== 1'b0) begin
            errors++;
            $display("FAIL latency_1cycle: pixel_on=%b expected=0", pixel_on);
        end
        tick();
        checks++;
        if (pixel_on !== e || e !== 1'b1) begin
            errors++;
            $display("FAIL latency_2cycle: pixel_on=%b expected=%b", pixel_on, e);
        end
        x_px = 10'(X0 + 5*CW);
        tick();
        tick();
        checks++;
        if (pixel_on !== 1'b0) begin
            errors++;
            $display("FAIL right_edge: pixel_on=%b expected=0", pixel_on);
        end
        x_px = 10'(X0);
        y_px = 10'(Y0);
        e    = exp_pix(X0, Y0);
        tick();
        tick();
        checks++;
        if (pixel_on !== e) begin
            errors++;
            $display("FAIL origin_pixel: pixel_on=%b expected=%b", pixel_on, e);
        end
    endtask

    initial begin
        reset    = 1'b1;
        x_px     = 10'd5;
        y_px     = 10'd5;
        values   = '0;
        dec_mode = 1'b0;
        test_reset();
        test_hex();
        test_decimal();
        test_snapshot();
        test_reset_mid();
        test_latency();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/numbers_overlay.md
Name: numbers_overlay

Overview:
Parametrised successor to the on-screen number renderer. It draws NUM_CH 16-bit values as rows of 8x8 glyphs on the VGA raster, with each glyph scaled by 2^SCALE_SH. Each value is shown in hex or decimal. All values are snapshotted at frame start and converted by a sequential double-dabble engine, so the display never tears mid-frame. It sits between the scope capture/measurement logic and the VGA pixel mux, and drives a 1-bit overlay pixel.

Parameters:
NUM_CH, 3, number of displayed channels (1..8)
X0, 16, left pixel column of the number block
Y0, 16, top pixel row of channel 0 (must be >= 1)
SCALE_SH, 1, glyph scale shift; character cell is CW = 8<<SCALE_SH pixels square
ROW_PITCH, 24, vertical pixel distance between channel rows (must be >= CW)

Ports:
clk  in  1  pixel clock
reset  in  1  synchronous, active-high reset
x_px  in  10  current raster column
y_px  in  10  current raster row
values  in  NUM_CH*16  channel values; channel c occupies bits [16c+15:16c]
dec_mode  in  1  1 = decimal, 0 = hex; sampled at frame start
pixel_on  out  1  overlay pixel, 2-cycle latency from x_px/y_px
busy  out  1  conversion engine active

Behaviour:
- Reset: pixel_on=0, busy=0, FSM=IDLE. Display bank cleared to all-zero digits with the mode flag set to hex, so every row shows " 0000".
- Frame start: trigger is x_px==0 && y_px==0 sampled on a clock edge while the FSM is IDLE.
  - On the trigger, values is latched into a shadow register and dec_mode is latched.
  - A trigger while busy is ignored.
  - After the snapshot, changes on values have no effect until the next trigger.
- FSM states: IDLE -> LOAD(c) -> [SHIFT x16, decimal only] -> next channel LOAD, or COMMIT -> IDLE.
  - LOAD: working reg = shadow value c; BCD accumulator = 0 (decimal). In hex, the 4 nibbles are written directly and the FSM advances.
  - SHIFT, one per cycle, 16 cycles: every BCD nibble >= 5 gets +3, then {bcd, bin} shifts left by 1. After the 16th shift, 5 BCD digits are written to the working bank for channel c.
  - COMMIT: the working bank is copied to the display bank in one cycle, along with the mode flag.
- busy is high from the cycle after the trigger through the COMMIT cycle inclusive.
  - Hex: NUM_CH+1 cycles.
  - Decimal: 17*NUM_CH+1 cycles.
- The display bank is only written at COMMIT. Rendering always uses a complete, consistent bank.
- Layout: channel c occupies rows [Y0+c*ROW_PITCH, Y0+c*ROW_PITCH+CW) and columns [X0, X0+5*CW). Digit position d=0..4 runs left to right.
  - Decimal: d0..d4 = ten-thousands..units. Leading zeros are shown.
  - Hex: d0 is blank; d1..d4 = nibbles [15:12]..[3:0]. Glyphs A-F are uppercase.
- Glyph addressing:
  - Glyph row = (y_px - row_top) >> SCALE_SH.
  - Glyph col = ((x_px - X0) - d*CW) >> SCALE_SH.
  - ROM bit 7 is the leftmost pixel. The blank glyph is all zeros.
- Pipeline:
  - Stage 1 registers: in-region flag, channel, digit index, glyph row, glyph col.
  - Stage 2: ROM lookup plus bit select, registered into pixel_on.
  - Outside every region, pixel_on=0. Rows between channels (ROW_PITCH > CW) are outside.
- Internal ROM: 17 entries (0-9, A-F, blank) x 8 rows x 8 bits. The bench uses the same table as its golden model.
- Arithmetic: x/y comparisons use 11-bit unsigned arithmetic, so values below X0 or Y0 never wrap into a region.
- Reset asserted mid-conversion: FSM returns to IDLE and busy=0 on the next edge. The display bank is cleared per reset rules. The first trigger after reset restarts cleanly.
- Trigger and reset in the same cycle: reset wins.

Test Plan:
1. Reset for 2 cycles, raster one frame with no trigger -> pixel_on=0 and busy=0 throughout reset; after reset, every row renders " 0000" per the golden font.
2. Hex mode, values = {0x1010, 0xAAAA, 0x1111}, trigger at (0,0) -> busy high exactly 4 cycles; rows 0..2 render " 1111", " AAAA", " 1010".
3. Decimal mode, values = {1234, 0, 65535} -> busy high exactly 52 cycles; rows render "65535", "00000", "01234".
4. After the trigger, change all values to 0xFFFF mid-frame -> display unchanged for the rest of the frame; the next trigger shows the new values.
5. Assert reset at busy cycle 20 of a decimal conversion -> busy=0 on the next edge; display shows " 0000"; the following trigger converts correctly.
6. Present x_px=X0, y_px=Y0 and compare against the golden pixel -> the result appears on pixel_on exactly 2 cycles later. x_px=X0-1 and x_px=X0+5*CW both give pixel_on=0.
